// File: rtl/core_clock_pkg.sv
// Shared types and constants for the core clock request controller.
package core_clock_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    SLEEP = 2'd2,
    WAKE  = 2'd3
  } core_clock_state_t;

  localparam int CORE_CLOCK_CW = 8;

endpackage

// File: rtl/core_clock_hold_ctr.sv
// Loadable down-counter that saturates at zero; clear beats load beats decrement.
module core_clock_hold_ctr
  import core_clock_pkg::*;
#(
  parameter logic [CORE_CLOCK_CW-1:0] RST_VAL = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clr_i,
  input  logic                     load_i,
  input  logic [CORE_CLOCK_CW-1:0] load_val_i,
  output logic                     zero_o
);

  logic [CORE_CLOCK_CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CORE_CLOCK_CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/core_clock_req.sv
// Core clock request controller: WFI sleep/wake handshake, memory-drain interlock
// and multiplier clock hysteresis, with all requests registered from the next state.
module core_clock_req
  import core_clock_pkg::*;
#(
  parameter logic        CLK_GATE_EN  = 1'b1,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned MUL_HOLD     = 8
) (
  input  logic f_clk,
  input  logic g_reset,
  input  logic sleep_req,
  input  logic mem_idle,
  input  logic irq_pending,
  input  logic dbg_req,
  input  logic rf_act,
  input  logic mul_act,
  output logic sleep_ack,
  output logic wake,
  output logic g_clk_req,
  output logic g_clk_rf_req,
  output logic g_clk_mul_req
);

  localparam logic [CORE_CLOCK_CW-1:0] DRAIN_LD = CORE_CLOCK_CW'(DRAIN_CYCLES - 1);
  localparam logic [CORE_CLOCK_CW-1:0] MUL_LD   = CORE_CLOCK_CW'(MUL_HOLD - 1);

  core_clock_state_t state_q, state_d;
  logic wake_src, awake_d, drain_load, drain_zero, mul_zero;
  logic sleep_ack_q, wake_q, clk_req_q, rf_req_q, mul_req_q;

  assign wake_src   = irq_pending | dbg_req;
  assign awake_d    = (state_d != SLEEP);
  assign drain_load = (state_q == RUN) && (state_d == DRAIN);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:   if (sleep_req && !wake_src && !mul_act) state_d = DRAIN;
      // Abort wins over completion so a late interrupt never stops the clock.
      DRAIN: if (wake_src || !sleep_req)            state_d = RUN;
             else if (drain_zero && mem_idle)       state_d = SLEEP;
      SLEEP: if (wake_src)                          state_d = WAKE;
      WAKE:  if (!sleep_req)                        state_d = RUN;
      default:                                      state_d = RUN;
    endcase
  end

  core_clock_hold_ctr #(.RST_VAL('0)) u_drain_ctr (
    .clk_i      (f_clk),
    .rst_i      (g_reset),
    .clr_i      (1'b0),
    .load_i     (drain_load),
    .load_val_i (DRAIN_LD),
    .zero_o     (drain_zero)
  );

  // Reset value keeps the multiplier clocked long enough for its own reset.
  core_clock_hold_ctr #(.RST_VAL(MUL_LD)) u_mul_ctr (
    .clk_i      (f_clk),
    .rst_i      (g_reset),
    .clr_i      (state_q == SLEEP),
    .load_i     (mul_act),
    .load_val_i (MUL_LD),
    .zero_o     (mul_zero)
  );

  always_ff @(posedge f_clk) begin
    if (g_reset) begin
      state_q     <= RUN;
      sleep_ack_q <= 1'b0;
      wake_q      <= 1'b0;
      clk_req_q   <= 1'b1;
      rf_req_q    <= 1'b1;
      mul_req_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      sleep_ack_q <= (state_d == SLEEP);
      wake_q      <= (state_d == WAKE);
      clk_req_q   <= !CLK_GATE_EN || awake_d;
      rf_req_q    <= !CLK_GATE_EN || (awake_d && (rf_act || state_d == WAKE));
      mul_req_q   <= !CLK_GATE_EN || (awake_d && (mul_act || !mul_zero));
    end
  end

  assign sleep_ack     = sleep_ack_q;
  assign wake          = wake_q;
  assign g_clk_req     = clk_req_q;
  assign g_clk_rf_req  = rf_req_q;
  assign g_clk_mul_req = mul_req_q;

endmodule
